// File: rtl/hps_io_pio.sv
// hps_io_pio: LED, button and switch PIO on the lightweight HPS-to-FPGA bridge.
// Blink/PWM LED modes, synchronised and debounced inputs, edge capture, maskable irq.
module hps_io_pio #(
   parameter int N_LED     = 8,
   parameter int N_KEY     = 2,
   parameter int N_SW      = 4,
   parameter int DEBOUNCE  = 50000,
   parameter int BLINK_DIV = 25000000,
   parameter int PWM_BITS  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [N_KEY-1:0] key_in,
   input  logic [N_SW-1:0]  sw_in,
   output logic [N_LED-1:0] led_out
);

   localparam int NV = N_KEY + N_SW;
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int BW = $clog2(BLINK_DIV);

   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE - 1);
   localparam logic [DW-1:0] DEB_ONE = DW'(1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
   localparam logic [BW-1:0] BLK_ONE = BW'(1);
   localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

   logic [N_LED-1:0]    led_data;
   logic [2*N_LED-1:0]  led_mode;
   logic [PWM_BITS-1:0] pwm_duty;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_on;
   logic [BW-1:0]       presc;
   logic                blink_ph;
   logic [N_LED-1:0]    led_nxt;

   logic [NV-1:0] irq_mask;
   logic [NV-1:0] edge_cap;
   logic [NV-1:0] edge_sel;
   logic [NV-1:0] edge_hit;
   logic [NV-1:0] w1c;

   logic [NV-1:0] sync1;
   logic [NV-1:0] sync2;
   logic [NV-1:0] deb;
   logic [NV-1:0] deb_d;
   logic [DW-1:0] deb_cnt [NV];

   logic [31:0] rdata;
   logic        unused_bits;

   assign unused_bits = ^writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_data <= '0;
         led_mode <= '0;
         pwm_duty <= '0;
         irq_mask <= '0;
         edge_sel <= '0;
      end else if (write) begin
         case (address)
            3'd0: led_data <= writedata[N_LED-1:0];
            3'd1: led_mode <= writedata[2*N_LED-1:0];
            3'd2: pwm_duty <= writedata[PWM_BITS-1:0];
            3'd5: irq_mask <= writedata[NV-1:0];
            3'd7: edge_sel <= writedata[NV-1:0];
            default: ;
         endcase
      end
   end

   // Idle level is high, so the sync chain resets to ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
         deb   <= '1;
         deb_d <= '1;
         for (int i = 0; i < NV; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= {sw_in, key_in};
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < NV; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_MAX) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
            end
         end
      end
   end

   // sel=1 passes any change; sel=0 keeps only falling (prev high).
   assign edge_hit = (deb ^ deb_d) & (edge_sel | deb_d);
   assign w1c = (write && address == 3'd6) ? writedata[NV-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) edge_cap <= '0;
      else       edge_cap <= (edge_cap & ~w1c) | edge_hit;
   end

   assign irq = |(edge_cap & irq_mask);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc    <= '0;
         blink_ph <= 1'b0;
         pwm_cnt  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_ONE;
         if (presc == BLK_MAX) begin
            presc    <= '0;
            blink_ph <= ~blink_ph;
         end else begin
            presc <= presc + BLK_ONE;
         end
      end
   end

   assign pwm_on = pwm_cnt < pwm_duty;

   always_comb begin
      led_nxt = '0;
      for (int i = 0; i < N_LED; i++) begin
         case (led_mode[2*i +: 2])
            2'b00:   led_nxt[i] = led_data[i];
            2'b01:   led_nxt[i] = led_data[i] & blink_ph;
            2'b10:   led_nxt[i] = led_data[i] & pwm_on;
            default: led_nxt[i] = led_data[i] & ~blink_ph;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) led_out <= '0;
      else       led_out <= led_nxt;
   end

   always_comb begin
      rdata = '0;
      case (address)
         3'd0: rdata[N_LED-1:0]    = led_data;
         3'd1: rdata[2*N_LED-1:0]  = led_mode;
         3'd2: rdata[PWM_BITS-1:0] = pwm_duty;
         3'd3: rdata[N_KEY-1:0]    = deb[N_KEY-1:0];
         3'd4: rdata[N_SW-1:0]     = deb[NV-1:N_KEY];
         3'd5: rdata[NV-1:0]       = irq_mask;
         3'd6: rdata[NV-1:0]       = edge_cap;
         3'd7: rdata[NV-1:0]       = edge_sel;
         default: ;
      endcase
   end

   // Sampled before any same-cycle write lands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     readdata <= '0;
      else if (read) readdata <= rdata;
   end

endmodule

// File: tb/tb_hps_io_pio.sv
// tb_hps_io_pio: scoreboard bench for hps_io_pio.
// Small parameters keep blink, PWM and debounce windows short.
module tb_hps_io_pio;

   localparam int N_LED = 8;
   localparam int N_KEY = 2;
   localparam int N_SW  = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [2:0]       address = '0;
   logic             read = 1'b0;
   logic             write = 1'b0;
   logic [31:0]      writedata = '0;
   logic [31:0]      readdata;
   logic             irq;
   logic [N_KEY-1:0] key_in = '1;
   logic [N_SW-1:0]  sw_in = '1;
   logic [N_LED-1:0] led_out;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [31:0] exp_q[$];

   hps_io_pio #(
      .N_LED(N_LED), .N_KEY(N_KEY), .N_SW(N_SW),
      .DEBOUNCE(4), .BLINK_DIV(8), .PWM_BITS(4)
   ) dut (
      .clk(clk), .reset(reset),
      .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata),
      .irq(irq), .key_in(key_in), .sw_in(sw_in),
      .led_out(led_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      address = a; read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      d = readdata;
   endtask

   task automatic test_reset();
      logic [31:0] got, e;
      @(negedge clk);
      total++;
      if (led_out !== 8'h00 || irq !== 1'b0 || readdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_out got led=%h irq=%b rd=%h exp 0",
                  led_out, irq, readdata);
      end
      reset = 1'b0;
      exp_q.push_back(32'h3);
      bus_rd(3'd3, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL reset_key got=%h exp=%h", got, e);
      end
      exp_q.push_back(32'hF);
      bus_rd(3'd4, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL reset_sw got=%h exp=%h", got, e);
      end
      exp_q.push_back(32'h0);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL reset_cap got=%h exp=%h", got, e);
      end
   endtask

   task automatic test_static();
      logic [31:0] got, e;
      bus_wr(3'd0, 32'hA5);
      exp_q.push_back(32'h00);
      e = exp_q.pop_front(); total++;
      if ({24'h0, led_out} !== e) begin
         bad++; $display("FAIL static_early got=%h exp=%h", led_out, e);
      end
      exp_q.push_back(32'hA5);
      @(negedge clk);
      e = exp_q.pop_front(); total++;
      if ({24'h0, led_out} !== e) begin
         bad++; $display("FAIL static_led got=%h exp=%h", led_out, e);
      end
      exp_q.push_back(32'h000000A5);
      bus_rd(3'd0, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL static_rd got=%h exp=%h", got, e);
      end
   endtask

   task automatic test_regs();
      logic [31:0] got, e;
      bus_wr(3'd0, 32'h3C);
      exp_q.push_back(32'h3C);
      address = 3'd0; writedata = 32'hC3;
      read = 1'b1; write = 1'b1;
      @(negedge clk);
      read = 1'b0; write = 1'b0;
      got = readdata; e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL rw_same_cycle got=%h exp=%h", got, e);
      end
      exp_q.push_back(32'hC3);
      bus_rd(3'd0, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL rw_after got=%h exp=%h", got, e);
      end
      bus_wr(3'd2, 32'hFFFF_FFFF);
      exp_q.push_back(32'hF);
      bus_rd(3'd2, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL duty_width got=%h exp=%h", got, e);
      end
      bus_wr(3'd1, 32'hFFFF_FFFF);
      exp_q.push_back(32'hFFFF);
      bus_rd(3'd1, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL mode_width got=%h exp=%h", got, e);
      end
      bus_wr(3'd5, 32'hFFFF_FFFF);
      exp_q.push_back(32'h3F);
      bus_rd(3'd5, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL mask_width got=%h exp=%h", got, e);
      end
      bus_wr(3'd3, 32'h0);
      exp_q.push_back(32'h3);
      bus_rd(3'd3, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL key_ro got=%h exp=%h", got, e);
      end
      bus_wr(3'd5, 32'h0);
      bus_wr(3'd1, 32'h0);
      bus_wr(3'd2, 32'h0);
   endtask

   task automatic test_blink();
      logic [31:0] e;
      int n;
      bus_wr(3'd0, 32'h03);
      bus_wr(3'd1, 32'h0D);
      for (int k = 0; k < 24; k++) begin
         n = cyc;
         exp_q.push_back(((n / 8) % 2 == 1) ? 32'h1 : 32'h2);
         @(negedge clk);
         e = exp_q.pop_front(); total++;
         if ({24'h0, led_out} !== e) begin
            bad++;
            $display("FAIL blink cyc=%0d got=%h exp=%h", cyc, led_out, e);
         end
      end
   endtask

   task automatic test_pwm();
      logic [31:0] e;
      int n, highs;
      bus_wr(3'd2, 32'h4);
      bus_wr(3'd0, 32'h01);
      bus_wr(3'd1, 32'h02);
      highs = 0;
      for (int k = 0; k < 32; k++) begin
         n = cyc;
         exp_q.push_back(((n % 16) < 4) ? 32'h1 : 32'h0);
         @(negedge clk);
         if (led_out[0]) highs++;
         e = exp_q.pop_front(); total++;
         if ({24'h0, led_out} !== e) begin
            bad++;
            $display("FAIL pwm4 cyc=%0d got=%h exp=%h", cyc, led_out, e);
         end
      end
      total++;
      if (highs !== 8) begin
         bad++; $display("FAIL pwm4_count got=%0d exp=8", highs);
      end
      bus_wr(3'd2, 32'h0);
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(32'h0);
         @(negedge clk);
         e = exp_q.pop_front(); total++;
         if ({24'h0, led_out} !== e) begin
            bad++; $display("FAIL pwm0 got=%h exp=%h", led_out, e);
         end
      end
   endtask

   task automatic test_debounce();
      logic [31:0] got, e;
      bus_wr(3'd7, 32'h0);
      bus_wr(3'd5, 32'h0);
      key_in[0] = 1'b0;
      repeat (2) @(negedge clk);
      key_in[0] = 1'b1;
      repeat (10) @(negedge clk);
      exp_q.push_back(32'h3);
      bus_rd(3'd3, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL glitch_key got=%h exp=%h", got, e);
      end
      exp_q.push_back(32'h0);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL glitch_cap got=%h exp=%h", got, e);
      end
      key_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      exp_q.push_back(32'h3);
      bus_rd(3'd3, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL key_early got=%h exp=%h", got, e);
      end
      exp_q.push_back(32'h2);
      bus_rd(3'd3, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL key_latency got=%h exp=%h", got, e);
      end
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL irq_masked got=%b exp=0", irq);
      end
      exp_q.push_back(32'h1);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL key_cap got=%h exp=%h", got, e);
      end
      bus_wr(3'd5, 32'h1);
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL irq_unmasked got=%b exp=1", irq);
      end
      bus_wr(3'd6, 32'h1);
      total++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL irq_w1c got=%b exp=0", irq);
      end
      key_in[0] = 1'b1;
      repeat (10) @(negedge clk);
      exp_q.push_back(32'h0);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL rise_ignored got=%h exp=%h", got, e);
      end
   endtask

   task automatic test_w1c_race();
      logic [31:0] got, e;
      bus_wr(3'd7, 32'h4);
      sw_in[0] = 1'b0;
      repeat (10) @(negedge clk);
      exp_q.push_back(32'h4);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL sw_fall_cap got=%h exp=%h", got, e);
      end
      sw_in[0] = 1'b1;
      repeat (6) @(negedge clk);
      bus_wr(3'd6, 32'h4);
      exp_q.push_back(32'h4);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL set_wins got=%h exp=%h", got, e);
      end
      bus_wr(3'd6, 32'h4);
      exp_q.push_back(32'h0);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL plain_w1c got=%h exp=%h", got, e);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] got, e;
      int n;
      bit seen;
      bus_wr(3'd5, 32'h4);
      sw_in[0] = 1'b0;
      bus_wr(3'd0, 32'h1);
      bus_wr(3'd1, 32'h1);
      repeat (8) @(negedge clk);
      sw_in[0] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (led_out[0]) seen = 1'b1;
      end
      total++;
      if (!seen || irq !== 1'b1) begin
         bad++; $display("FAIL pre_reset led_seen=%b irq=%b exp 1/1", seen, irq);
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (led_out !== 8'h00 || irq !== 1'b0 || dut.edge_cap !== 6'h0) begin
         bad++;
         $display("FAIL async_reset led=%h irq=%b cap=%h exp 0",
                  led_out, irq, dut.edge_cap);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back(32'h0);
      bus_rd(3'd6, got); e = exp_q.pop_front(); total++;
      if (got !== e) begin
         bad++; $display("FAIL post_reset_cap got=%h exp=%h", got, e);
      end
      bus_wr(3'd1, 32'h1);
      bus_wr(3'd0, 32'h1);
      for (int k = 0; k < 20; k++) begin
         n = cyc;
         exp_q.push_back(((n / 8) % 2 == 1) ? 32'h1 : 32'h0);
         @(negedge clk);
         e = exp_q.pop_front(); total++;
         if ({24'h0, led_out} !== e) begin
            bad++;
            $display("FAIL blink_restart cyc=%0d got=%h exp=%h", cyc, led_out, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_regs();
      test_blink();
      test_pwm();
      test_debounce();
      test_w1c_race();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
